// File: rtl/ucsbece154_sdram_burst_ctrl.sv
// SDRAM refill controller + read-only word store: block refill, T_ACCESS latency, periodic refresh.
// No backpressure: words stream one per cycle while ReqValid is held; dropping ReqValid aborts.
module ucsbece154_sdram_burst_ctrl #(
    parameter int    BLOCK_WORDS    = 4,
    parameter int    MEM_WORDS      = 16384,
    parameter int    T_ACCESS       = 4,
    parameter int    REFRESH_PERIOD = 256,
    parameter int    T_REFRESH      = 3,
    parameter string INIT_FILE      = ""
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] ReqAddress,
    input  logic        ReqValid,
    output logic [31:0] DataOut,
    output logic        DataReady,
    output logic        Busy,
    output logic        RefreshActive
);

    localparam int AW      = $clog2(MEM_WORDS);
    localparam int BB      = $clog2(BLOCK_WORDS);
    localparam int LAT_MAX = (T_ACCESS > T_REFRESH) ? T_ACCESS : T_REFRESH;
    localparam int LCW     = $clog2(LAT_MAX + 1);
    localparam int RCW     = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

    // ACCESS lasts T_ACCESS-1 cycles so the first word is registered in the T_ACCESS-th cycle.
    localparam logic [LCW-1:0] LAT_ACCESS  = (T_ACCESS > 1) ? LCW'(T_ACCESS - 2) : '0;
    localparam logic [LCW-1:0] LAT_REFRESH = LCW'(T_REFRESH - 1);
    localparam logic [BB-1:0]  LAST_BEAT   = BB'(BLOCK_WORDS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REFRESH = 3'd1;
    localparam logic [2:0] S_ACCESS  = 3'd2;
    localparam logic [2:0] S_BURST   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [31:0] mem_array [MEM_WORDS];

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem_array[i] = 32'h0;
    end

    logic [2:0]     state_q, state_d;
    logic [AW-1:0]  base_q, base_d;
    logic [LCW-1:0] lat_q, lat_d;
    logic [BB-1:0]  beat_q, beat_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic           pend_q, pend_d;
    logic [31:0]    data_q, data_d;
    logic           rdy_q, rdy_d;
    logic           busy_q, refact_q;

    logic [AW-1:0]  req_base;
    logic [AW-1:0]  rd_idx;
    logic           load;
    logic           expire;
    logic           unused_addr;

    assign req_base    = {ReqAddress[AW+1:BB+2], {BB{1'b0}}};
    assign unused_addr = ^{ReqAddress[31:AW+2], ReqAddress[BB+1:0]};

    always_comb begin
        rcnt_d = '0;
        expire = 1'b0;
        if (REFRESH_PERIOD != 0) begin
            if (rcnt_q == RCW'(REFRESH_PERIOD - 1)) expire = 1'b1;
            else                                    rcnt_d = rcnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        pend_d  = pend_q | expire;
        rd_idx  = '0;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    state_d = S_REFRESH;
                    lat_d   = LAT_REFRESH;
                    pend_d  = expire;
                end else if (ReqValid) begin
                    base_d = req_base;
                    if (T_ACCESS == 1) begin
                        state_d = S_BURST;
                        beat_d  = '0;
                        rd_idx  = req_base;
                        load    = 1'b1;
                    end else begin
                        state_d = S_ACCESS;
                        lat_d   = LAT_ACCESS;
                    end
                end
            end
            S_REFRESH: begin
                if (lat_q == '0) state_d = S_IDLE;
                else             lat_d   = lat_q - 1'b1;
            end
            S_ACCESS: begin
                if (!ReqValid) begin
                    state_d = S_IDLE;
                end else if (lat_q == '0) begin
                    state_d = S_BURST;
                    beat_d  = '0;
                    rd_idx  = base_q;
                    load    = 1'b1;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            S_BURST: begin
                // The last word always completes; abort only applies before it.
                if (beat_q == LAST_BEAT) begin
                    state_d = S_DONE;
                end else if (!ReqValid) begin
                    state_d = S_IDLE;
                end else begin
                    beat_d = beat_q + 1'b1;
                    rd_idx = base_q | {{(AW-BB){1'b0}}, beat_q + 1'b1};
                    load   = 1'b1;
                end
            end
            S_DONE: begin
                if (!ReqValid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        data_d = load ? mem_array[rd_idx] : 32'h0;
        rdy_d  = load;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            lat_q    <= '0;
            beat_q   <= '0;
            rcnt_q   <= '0;
            pend_q   <= 1'b0;
            data_q   <= 32'h0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            refact_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            lat_q    <= lat_d;
            beat_q   <= beat_d;
            rcnt_q   <= rcnt_d;
            pend_q   <= pend_d;
            data_q   <= data_d;
            rdy_q    <= rdy_d;
            busy_q   <= (state_d != S_IDLE);
            refact_q <= (state_d == S_REFRESH);
        end
    end

    assign DataOut       = data_q;
    assign DataReady     = rdy_q;
    assign Busy          = busy_q;
    assign RefreshActive = refact_q;

endmodule

// File: tb/tb_ucsbece154_sdram_burst_ctrl.sv
// Directed bench: dut0 runs without refresh (refill, DONE hold, abort, reset); dut1 refreshes every 16 cycles.
module tb_ucsbece154_sdram_burst_ctrl;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        rst0, vld0, rdy0, busy0, ref0;
    logic [31:0] addr0, dout0;
    logic        rst1, vld1, rdy1, busy1, ref1;
    logic [31:0] addr1, dout1;

    int errors = 0;
    int checks = 0;

    ucsbece154_sdram_burst_ctrl #(
        .BLOCK_WORDS(4), .MEM_WORDS(16384), .T_ACCESS(4),
        .REFRESH_PERIOD(0), .T_REFRESH(3), .INIT_FILE("")
    ) u_dut0 (
        .Clk(Clk), .Reset(rst0), .ReqAddress(addr0), .ReqValid(vld0),
        .DataOut(dout0), .DataReady(rdy0), .Busy(busy0), .RefreshActive(ref0)
    );

    ucsbece154_sdram_burst_ctrl #(
        .BLOCK_WORDS(4), .MEM_WORDS(16384), .T_ACCESS(4),
        .REFRESH_PERIOD(16), .T_REFRESH(3), .INIT_FILE("")
    ) u_dut1 (
        .Clk(Clk), .Reset(rst1), .ReqAddress(addr1), .ReqValid(vld1),
        .DataOut(dout1), .DataReady(rdy1), .Busy(busy1), .RefreshActive(ref1)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic o0(input string tag, input logic rdy, input logic [31:0] dat, input logic busy);
        chk({tag, ".rdy"},  {31'b0, rdy0},  {31'b0, rdy});
        chk({tag, ".data"}, dout0,          dat);
        chk({tag, ".busy"}, {31'b0, busy0}, {31'b0, busy});
        chk({tag, ".ref"},  {31'b0, ref0},  32'h0);
    endtask

    task automatic o1(input string tag, input logic rdy, input logic [31:0] dat,
                      input logic busy, input logic refa);
        chk({tag, ".rdy"},  {31'b0, rdy1},  {31'b0, rdy});
        chk({tag, ".data"}, dout1,          dat);
        chk({tag, ".busy"}, {31'b0, busy1}, {31'b0, busy});
        chk({tag, ".ref"},  {31'b0, ref1},  {31'b0, refa});
    endtask

    initial begin
        rst0 = 1'b1; vld0 = 1'b0; addr0 = 32'h0;
        rst1 = 1'b1; vld1 = 1'b0; addr1 = 32'h0;
        #1;
        for (int i = 0; i < 16384; i++) begin
            u_dut0.mem_array[i] = 32'h10000000 + i;
            u_dut1.mem_array[i] = 32'h10000000 + i;
        end

        // ---------------- dut0: no refresh ----------------
        step();
        o0("reset0", 1'b0, 32'h0, 1'b0);
        rst0 = 1'b0; vld0 = 1'b1; addr0 = 32'h00000034;

        step();
        o0("basic_acc1", 1'b0, 32'h0, 1'b1);
        for (int k = 2; k <= 3; k++) begin
            step();
            o0($sformatf("basic_acc%0d", k), 1'b0, 32'h0, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            o0($sformatf("basic_w%0d", k), 1'b1, 32'h1000000C + k, 1'b1);
        end
        step();
        o0("basic_done", 1'b0, 32'h0, 1'b1);
        step();
        o0("done_hold", 1'b0, 32'h0, 1'b1);
        vld0 = 1'b0;
        step();
        o0("basic_idle", 1'b0, 32'h0, 1'b0);

        // abort after two words, then refill from 0x40
        vld0 = 1'b1; addr0 = 32'h00000034;
        for (int k = 1; k <= 3; k++) begin
            step();
            o0($sformatf("abort_acc%0d", k), 1'b0, 32'h0, 1'b1);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            o0($sformatf("abort_w%0d", k), 1'b1, 32'h1000000C + k, 1'b1);
        end
        vld0 = 1'b0;
        step();
        o0("abort_drop", 1'b0, 32'h0, 1'b0);
        vld0 = 1'b1; addr0 = 32'h00000040;
        for (int k = 1; k <= 3; k++) begin
            step();
            o0($sformatf("post_abort_acc%0d", k), 1'b0, 32'h0, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            o0($sformatf("post_abort_w%0d", k), 1'b1, 32'h10000010 + k, 1'b1);
        end
        step();
        o0("post_abort_done", 1'b0, 32'h0, 1'b1);
        vld0 = 1'b0;
        step();
        o0("post_abort_idle", 1'b0, 32'h0, 1'b0);

        // reset during ACCESS with ReqValid held
        vld0 = 1'b1; addr0 = 32'h00000080;
        step();
        o0("rst_acc1", 1'b0, 32'h0, 1'b1);
        step();
        rst0 = 1'b1;
        step();
        o0("rst_mid", 1'b0, 32'h0, 1'b0);
        rst0 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            o0($sformatf("rst_reacc%0d", k), 1'b0, 32'h0, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            o0($sformatf("rst_w%0d", k), 1'b1, 32'h10000020 + k, 1'b1);
        end
        step();
        o0("rst_done", 1'b0, 32'h0, 1'b1);
        vld0 = 1'b0;
        step();
        o0("rst_idle", 1'b0, 32'h0, 1'b0);

        // ---------------- dut1: refresh every 16 cycles ----------------
        step();
        o1("reset1", 1'b0, 32'h0, 1'b0, 1'b0);
        rst1 = 1'b0;
        for (int n = 1; n <= 16; n++) step();
        // refresh_pending becomes set on this cycle; request arrives simultaneously
        vld1 = 1'b1; addr1 = 32'h00000040;
        o1("prio_pend", 1'b0, 32'h0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step();
            o1($sformatf("prio_ref%0d", k), 1'b0, 32'h0, 1'b1, 1'b1);
        end
        step();
        o1("prio_idle", 1'b0, 32'h0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step();
            o1($sformatf("prio_acc%0d", k), 1'b0, 32'h0, 1'b1, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            o1($sformatf("prio_w%0d", k), 1'b1, 32'h10000010 + k, 1'b1, 1'b0);
        end
        step();
        o1("prio_done", 1'b0, 32'h0, 1'b1, 1'b0);
        vld1 = 1'b0;
        step();
        o1("prio_end", 1'b0, 32'h0, 1'b0, 1'b0);

        // idle edges 30..42; the expiry at edge 32 refreshes during edges 33..35
        for (int n = 30; n <= 42; n++) begin
            step();
            o1($sformatf("idle_e%0d", n), 1'b0, 32'h0,
               (n >= 33 && n <= 35), (n >= 33 && n <= 35));
        end

        // accept at edge 43; expiry at edge 48 falls inside the burst; address wraps to word 4
        vld1 = 1'b1; addr1 = 32'h00010010;
        for (int k = 1; k <= 3; k++) begin
            step();
            o1($sformatf("defer_acc%0d", k), 1'b0, 32'h0, 1'b1, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            o1($sformatf("wrap_w%0d", k), 1'b1, 32'h10000004 + k, 1'b1, 1'b0);
        end
        step();
        o1("defer_done", 1'b0, 32'h0, 1'b1, 1'b0);
        vld1 = 1'b0;
        step();
        o1("defer_idle", 1'b0, 32'h0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step();
            o1($sformatf("defer_ref%0d", k), 1'b0, 32'h0, 1'b1, 1'b1);
        end
        step();
        o1("defer_end", 1'b0, 32'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
